// File: rtl/odom_sched_pkg.sv
// Shared types and default constants for the odometry sample scheduler.
package odom_sched_pkg;

  localparam int unsigned DefaultSamplePeriod = 5_000_000;
  localparam int unsigned DefaultDistW        = 32;
  localparam int unsigned DefaultIdxW         = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StCapture,
    StCompute,
    StPresent
  } sched_state_e;

endpackage

// File: rtl/sample_period_timer.sv
// Free-running period counter: counts 0..Period-1 while run_i is high, held at 0 otherwise.
module sample_period_timer
  import odom_sched_pkg::*;
#(
  parameter int unsigned Period = DefaultSamplePeriod
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(Period - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    if (run_i && (count_q != LastCount)) begin
      count_d = count_q + CntW'(1);
    end
  end

  assign tick_o = run_i && (count_q == LastCount);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/odometry_sample_scheduler.sv
// Periodic coherent wheel-distance sampler with per-interval deltas and valid/ready output.
// Optional ODOM_SCHED_HEADING_EN adds delta_diff_o = delta_right - delta_left.
module odometry_sample_scheduler
  import odom_sched_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = DefaultSamplePeriod,
  parameter int unsigned DIST_W        = DefaultDistW,
  parameter int unsigned IDX_W         = DefaultIdxW
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              enable_i,
  input  logic              clear_overrun_i,
  input  logic [DIST_W-1:0] distance_left_i,
  input  logic [DIST_W-1:0] distance_right_i,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic [DIST_W-1:0] delta_left_o,
  output logic [DIST_W-1:0] delta_right_o,
  output logic [IDX_W-1:0]  sample_index_o,
  output logic              overrun_o,
`ifdef ODOM_SCHED_HEADING_EN
  output logic [DIST_W:0]   delta_diff_o,
`endif
  output logic              busy_o
);

  sched_state_e state_q, state_d;

  logic [DIST_W-1:0] prev_left_q, prev_left_d, prev_right_q, prev_right_d;
  logic [DIST_W-1:0] cap_left_q, cap_left_d, cap_right_q, cap_right_d;
  logic [DIST_W-1:0] delta_left_q, delta_left_d, delta_right_q, delta_right_d;
  logic [DIST_W-1:0] new_left, new_right;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              overrun_q, overrun_d;
  logic              tick;

  // Timer keeps running through capture/compute/present so the period stays phase-locked.
  sample_period_timer #(
    .Period (SAMPLE_PERIOD)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .run_i    (state_q != StIdle),
    .tick_o   (tick)
  );

  // Modular subtraction handles wrap of the cumulative counters.
  assign new_left  = cap_left_q - prev_left_q;
  assign new_right = cap_right_q - prev_right_q;

  always_comb begin
    state_d       = state_q;
    prev_left_d   = prev_left_q;
    prev_right_d  = prev_right_q;
    cap_left_d    = cap_left_q;
    cap_right_d   = cap_right_q;
    delta_left_d  = delta_left_q;
    delta_right_d = delta_right_q;
    index_d       = index_q;

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          prev_left_d  = distance_left_i;
          prev_right_d = distance_right_i;
          state_d      = StWaitTick;
        end
      end
      StWaitTick: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (tick) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        cap_left_d  = distance_left_i;
        cap_right_d = distance_right_i;
        state_d     = StCompute;
      end
      StCompute: begin
        delta_left_d  = new_left;
        delta_right_d = new_right;
        prev_left_d   = cap_left_q;
        prev_right_d  = cap_right_q;
        state_d       = StPresent;
      end
      StPresent: begin
        if (sample_ready_i) begin
          index_d = index_q + IDX_W'(1);
          state_d = enable_i ? StWaitTick : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A tick dropped while presenting wins over a simultaneous clear.
    overrun_d = overrun_q;
    if (tick && (state_q == StPresent)) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      prev_left_q   <= '0;
      prev_right_q  <= '0;
      cap_left_q    <= '0;
      cap_right_q   <= '0;
      delta_left_q  <= '0;
      delta_right_q <= '0;
      index_q       <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_left_q   <= prev_left_d;
      prev_right_q  <= prev_right_d;
      cap_left_q    <= cap_left_d;
      cap_right_q   <= cap_right_d;
      delta_left_q  <= delta_left_d;
      delta_right_q <= delta_right_d;
      index_q       <= index_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef ODOM_SCHED_HEADING_EN
  logic [DIST_W:0] diff_q, diff_d;

  always_comb begin
    diff_d = diff_q;
    if (state_q == StCompute) begin
      diff_d = {new_right[DIST_W-1], new_right} - {new_left[DIST_W-1], new_left};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      diff_q <= '0;
    end else begin
      diff_q <= diff_d;
    end
  end

  assign delta_diff_o = diff_q;
`endif

  assign sample_valid_o = (state_q == StPresent);
  assign busy_o         = (state_q != StIdle);
  assign delta_left_o   = delta_left_q;
  assign delta_right_o  = delta_right_q;
  assign sample_index_o = index_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_odometry_sample_scheduler.sv
// Directed + randomized bench for odometry_sample_scheduler with a timestamp-based reference model.
module tb_odometry_sample_scheduler;

  localparam int unsigned P  = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          reset_n, enable, clear_ovr, ready;
  logic [DW-1:0] dist_l, dist_r;
  logic          sample_valid, overrun, busy;
  logic [DW-1:0] delta_left, delta_right;
  logic [IW-1:0] sample_index;
`ifdef ODOM_SCHED_HEADING_EN
  logic [DW:0]   delta_diff;
`endif

  always #5 clk = ~clk;

  odometry_sample_scheduler #(
    .SAMPLE_PERIOD (P),
    .DIST_W        (DW),
    .IDX_W         (IW)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .enable_i        (enable),
    .clear_overrun_i (clear_ovr),
    .distance_left_i (dist_l),
    .distance_right_i(dist_r),
    .sample_valid_o  (sample_valid),
    .sample_ready_i  (ready),
    .delta_left_o    (delta_left),
    .delta_right_o   (delta_right),
    .sample_index_o  (sample_index),
    .overrun_o       (overrun),
`ifdef ODOM_SCHED_HEADING_EN
    .delta_diff_o    (delta_diff),
`endif
    .busy_o          (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;  // index of the clock edge about to occur / current cycle

  // Reference model: running flag, baseline edge, pending-sample timestamps.
  bit            m_run, m_pend, m_ovr;
  int            m_base, m_cap, m_vf;
  logic [DW-1:0] m_prev_l, m_prev_r, m_new_l, m_new_r, m_dl, m_dr;
  logic [IW-1:0] m_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the rules for edge n using the inputs held across that edge.
  task automatic model_update();
    bit tick, pres;
    if (!reset_n) begin
      m_run = 0; m_pend = 0; m_ovr = 0; m_idx = '0; m_dl = '0; m_dr = '0;
      return;
    end
    tick = m_run && (((n - m_base) % int'(P)) == 0);
    pres = m_pend && (n >= m_vf);
    if (tick && pres) m_ovr = 1;
    else if (clear_ovr) m_ovr = 0;
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_base = n; m_prev_l = dist_l; m_prev_r = dist_r;
      end
    end else if (m_pend) begin
      if (n == m_cap) begin
        m_new_l = dist_l - m_prev_l; m_new_r = dist_r - m_prev_r;
        m_prev_l = dist_l; m_prev_r = dist_r;
      end
      if (n == m_cap + 1) begin
        m_dl = m_new_l; m_dr = m_new_r;
      end
      if (pres && ready) begin
        m_pend = 0; m_idx++;
        if (!enable) m_run = 0;
      end
    end else if (!enable) begin
      m_run = 0;
    end else if (tick) begin
      m_pend = 1; m_cap = n + 1; m_vf = n + 3;
    end
  endtask

  task automatic check_all();
    logic signed [DW-1:0] sl, sr;
    logic signed [DW:0]   ediff;
    check("valid", sample_valid, m_pend && (n >= m_vf));
    check("busy", busy, m_run);
    check("overrun", overrun, m_ovr);
    check("index", sample_index, m_idx);
    check("delta_left", delta_left, m_dl);
    check("delta_right", delta_right, m_dr);
    sl = m_dl; sr = m_dr;
    ediff = sr - sl;
`ifdef ODOM_SCHED_HEADING_EN
    check("delta_diff", delta_diff, ediff);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    n++;
    #1;
    check_all();
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !sample_valid; i++) step();
    check("wait_valid_timeout", sample_valid, 1'b1);
  endtask

  initial begin
    int b;
    logic [DW-1:0] hold_l, hold_r;
    reset_n = 0; enable = 0; clear_ovr = 0; ready = 0; dist_l = '0; dist_r = '0;
    step(); step();
    check("reset_valid", sample_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset_n = 1;
    step();

    // Basic sample: latency and signed deltas.
    enable = 1; ready = 1; dist_l = 1000; dist_r = 2000;
    b = n;
    step();
    repeat (3) step();
    dist_l = 1500; dist_r = 1800;
    wait_valid(30);
    check("first_latency", n, b + P + 3);
    check("first_dl", delta_left, 32'd500);
    check("first_dr", delta_right, 32'hFFFF_FF38);
    check("first_idx", sample_index, 16'd0);
`ifdef ODOM_SCHED_HEADING_EN
    check("first_diff", delta_diff, 33'h1_FFFF_FD44);
`endif
    step();
    check("accept_busy", busy, 1'b1);

    // Counter wrap.
    enable = 0; step(); step();
    check("idle_busy", busy, 1'b0);
    dist_l = 32'hFFFF_FF00; enable = 1;
    step();
    dist_l = 32'h0000_0100;
    wait_valid(30);
    check("wrap_dl", delta_left, 32'd512);
    step();

    // Stall across a tick: overrun, stable outputs, folded delta.
    ready = 0; dist_l = 32'h300;
    wait_valid(30);
    hold_l = delta_left; hold_r = delta_right;
    dist_l = 32'h1000;
    repeat (15) step();
    check("stall_overrun", overrun, 1'b1);
    check("stall_dl_stable", delta_left, hold_l);
    check("stall_dr_stable", delta_right, hold_r);
    ready = 1; step();
    wait_valid(30);
    check("folded_dl", delta_left, 32'hD00);
    step();
    clear_ovr = 1; step(); clear_ovr = 0;
    check("cleared_overrun", overrun, 1'b0);

    // Enable dropped while presenting.
    ready = 0;
    wait_valid(30);
    enable = 0; step(); step();
    check("drop_still_valid", sample_valid, 1'b1);
    ready = 1; step();
    check("drop_busy_low", busy, 1'b0);
    repeat (25) step();

    // Reset while in COMPUTE, then re-baseline.
    enable = 1; b = n;
    step();
    repeat (P + 1) step();
    reset_n = 0; step();
    check("rst_valid", sample_valid, 1'b0);
    check("rst_dl", delta_left, 32'd0);
    check("rst_idx", sample_index, 16'd0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1; enable = 0; step();
    dist_l = 7000; dist_r = 9000; enable = 1; step();
    dist_l = 7123; dist_r = 8999;
    wait_valid(30);
    check("rebase_dl", delta_left, 32'd123);
    check("rebase_dr", delta_right, 32'hFFFF_FFFF);
    step();

    // Randomized traffic checked every cycle by the model.
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 19) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      clear_ovr = ($urandom_range(0, 15) == 0);
      reset_n   = ($urandom_range(0, 249) != 0);
      dist_l    = dist_l + DW'($urandom_range(0, 600)) - DW'(300);
      dist_r    = dist_r + DW'($urandom_range(0, 600)) - DW'(300);
      if ($urandom_range(0, 49) == 0) dist_l = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/odometry_sample_scheduler.md
# odometry_sample_scheduler

Periodic sampling controller for the dual-wheel odometry datapath. It takes coherent snapshots of the cumulative left/right wheel distance counters on a fixed period and computes per-interval signed deltas. It presents each sample to a downstream consumer (telemetry/serial TX or pose integrator) over a valid/ready handshake, flagging overruns when the consumer stalls. It sits between the wheel-encoder interface and the consumer.

## Interface
- `SAMPLE_PERIOD`, 5_000_000: sample interval in clk cycles (100 ms at 50 MHz); must be ≥ 4.
- `DIST_W`, 32: width of distance inputs and delta outputs.
- `IDX_W`, 16: width of sample sequence counter.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  run sampling when high.
- `clear_overrun`  in  1  one-cycle pulse; clears sticky `overrun`.
- `distance_left`  in  DIST_W  cumulative left wheel distance (µm, wraps mod 2^DIST_W).
- `distance_right`  in  DIST_W  cumulative right wheel distance (µm, wraps mod 2^DIST_W).
- `sample_valid`  out  1  sample on outputs is valid.
- `sample_ready`  in  1  consumer accepts sample.
- `delta_left`  out  DIST_W  signed left distance since previous sample.
- `delta_right`  out  DIST_W  signed right distance since previous sample.
- `sample_index`  out  IDX_W  sequence number of presented sample.
- `overrun`  out  1  sticky: ≥1 tick dropped while a sample was pending.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT_TICK, CAPTURE, COMPUTE, PRESENT.
- IDLE: period counter held at 0. On `enable`=1, latch `distance_left/right` into `prev_left/right` as baseline, go to WAIT_TICK.
- WAIT_TICK: counter counts 0..SAMPLE_PERIOD-1, wrapping. Tick is `count == SAMPLE_PERIOD-1`; on tick go to CAPTURE. If `enable`=0, go to IDLE (no sample).
- CAPTURE: register both distance inputs in the same cycle (coherent snapshot) into `cap_left/right`.
- COMPUTE: `delta_x <= cap_x - prev_x` (DIST_W modular subtraction, interpreted as two's complement; wrap of cumulative counter handled implicitly). Then `prev_x <= cap_x`.
- PRESENT: `sample_valid`=1. Outputs stay stable until `sample_valid && sample_ready`. On acceptance, `sample_index` increments (wraps at 2^IDX_W) and the FSM goes to WAIT_TICK, or to IDLE if `enable`=0.
- The period counter runs freely in CAPTURE/COMPUTE/PRESENT, so the period stays phase-locked.
- A tick while in PRESENT sets `overrun` and is dropped. `prev` is not updated, so the missed interval folds into the next delta (no distance lost).
- `enable` deassert mid-sample: the current sample completes its handshake, then the FSM goes to IDLE. Re-enable re-baselines.
- Simultaneous `clear_overrun` and an overrun-setting tick: set wins.

## Timing
- Reset values: `sample_valid`=0, `delta_left/right`=0, `sample_index`=0, `overrun`=0, `busy`=0, counter=0, state=IDLE.
- Tick in cycle T (WAIT_TICK) → CAPTURE in T+1 (samples inputs present in T+1) → COMPUTE in T+2 → `sample_valid`=1 from T+3.
- Same-cycle acceptance (`sample_ready` already high) returns to WAIT_TICK at T+4.
- First tick occurs SAMPLE_PERIOD cycles after leaving IDLE.
- Reset mid-operation: all state returns to reset values next edge. No partial sample is emitted.

## Configuration
- `ODOM_SCHED_HEADING_EN` defined: adds output `delta_diff` (signed, DIST_W+1) = `delta_right - delta_left`, sign-extended. It is registered in COMPUTE alongside the deltas, valid with `sample_valid`, and resets to 0.
- Not defined: port and logic absent; behaviour otherwise identical.

## Structure
- Package `odom_sched_pkg`: FSM state enum, default `SAMPLE_PERIOD`, `DIST_W`, `IDX_W` constants.
- Sub-module `sample_period_timer`: period counter with `run` input and `tick` output; cleared when not running.

## Test plan
- SAMPLE_PERIOD=10; enable at cycle 0 with distances L=1000/R=2000; at tick inputs L=1500/R=1800; ready=1 → `sample_valid` 3 cycles after tick, `delta_left`=500, `delta_right`=-200, `sample_index`=0.
- Wrap: prev L=0xFFFF_FF00, capture L=0x0000_0100 → `delta_left`=+512.
- Stall ready=0 for 15 cycles across a tick → `overrun`=1, outputs stable. Next sample delta spans two periods; `clear_overrun` → 0.
- `enable` dropped during PRESENT with ready=0, then ready=1 → sample accepted, `busy`=0 next cycle, no further samples.
- Reset asserted in COMPUTE → all outputs 0 next cycle; after release and enable, new baseline taken.
- With `ODOM_SCHED_HEADING_EN`: deltas L=500/R=-200 → `delta_diff`=-700.
